// File: rtl/tl_rom_arbiter.sv
// Round-robin TileLink-UL arbiter in front of a single boot-ROM slave port.
// Ports: clk/rst_n, per-master m_a_*/m_d_* (packed, master i at slice i), slave s_a_*/s_d_*.
module tl_rom_arbiter #(
  parameter int N_REQ   = 2,
  parameter int SRC_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         m_a_valid,
  output logic [N_REQ-1:0]         m_a_ready,
  input  logic [3*N_REQ-1:0]       m_a_opcode,
  input  logic [2*N_REQ-1:0]       m_a_size,
  input  logic [SRC_W*N_REQ-1:0]   m_a_source,
  input  logic [64*N_REQ-1:0]      m_a_address,
  input  logic [64*N_REQ-1:0]      m_a_data,
  input  logic [8*N_REQ-1:0]       m_a_mask,
  output logic [N_REQ-1:0]         m_d_valid,
  input  logic [N_REQ-1:0]         m_d_ready,
  output logic [2:0]               m_d_opcode,
  output logic [1:0]               m_d_size,
  output logic [SRC_W-1:0]         m_d_source,
  output logic [63:0]              m_d_data,
  output logic                     m_d_denied,
  output logic                     s_a_valid,
  input  logic                     s_a_ready,
  output logic [2:0]               s_a_opcode,
  output logic [1:0]               s_a_size,
  output logic [SRC_W-1:0]         s_a_source,
  output logic [63:0]              s_a_address,
  output logic [63:0]              s_a_data,
  output logic [7:0]               s_a_mask,
  input  logic                     s_d_valid,
  output logic                     s_d_ready,
  input  logic [2:0]               s_d_opcode,
  input  logic [1:0]               s_d_size,
  input  logic [SRC_W-1:0]         s_d_source,
  input  logic [63:0]              s_d_data,
  input  logic                     s_d_denied
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT) + 1;

  localparam logic [2:0] OP_GET   = 3'd4;
  localparam logic [2:0] OP_ACK   = 3'd0;
  localparam logic [2:0] OP_ACK_D = 3'd1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  typedef struct packed {
    logic [2:0]       opcode;
    logic [1:0]       size;
    logic [SRC_W-1:0] source;
    logic [63:0]      address;
    logic [63:0]      data;
    logic [7:0]       mask;
  } a_t;

  typedef struct packed {
    logic [2:0]       opcode;
    logic [1:0]       size;
    logic [SRC_W-1:0] source;
    logic [63:0]      data;
    logic             denied;
  } d_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] own_q;
  logic [WD_W-1:0]  wdog_q;
  a_t               a_q;
  d_t               d_q;

  logic             found;
  logic [IDX_W-1:0] win;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;
  a_t               a_win;
  logic             to_hit;

  // Rotating priority scan starting at ptr_q.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N_REQ))
        sum = sum - (IDX_W+1)'(N_REQ);
      idx = sum[IDX_W-1:0];
      if (!found && m_a_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    a_win.opcode  = m_a_opcode[3*win +: 3];
    a_win.size    = m_a_size[2*win +: 2];
    a_win.source  = m_a_source[SRC_W*win +: SRC_W];
    a_win.address = m_a_address[64*win +: 64];
    a_win.data    = m_a_data[64*win +: 64];
    a_win.mask    = m_a_mask[8*win +: 8];
  end

  assign to_hit = (wdog_q == WD_W'(TIMEOUT-1));

  always_comb begin
    state_d   = state_q;
    m_a_ready = '0;
    m_d_valid = '0;
    s_a_valid = 1'b0;
    s_d_ready = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        s_d_ready = rst_n;
        if (found && rst_n) begin
          m_a_ready[win] = 1'b1;
          state_d        = S_ISSUE;
        end
      end
      S_ISSUE: begin
        s_a_valid = 1'b1;
        if (s_a_ready)
          state_d = S_WAIT;
      end
      S_WAIT: begin
        s_d_ready = 1'b1;
        if (s_d_valid || to_hit)
          state_d = S_RESP;
      end
      S_RESP: begin
        m_d_valid[own_q] = 1'b1;
        if (m_d_ready[own_q])
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    s_a_opcode  = s_a_valid ? a_q.opcode  : '0;
    s_a_size    = s_a_valid ? a_q.size    : '0;
    s_a_source  = s_a_valid ? a_q.source  : '0;
    s_a_address = s_a_valid ? a_q.address : '0;
    s_a_data    = s_a_valid ? a_q.data    : '0;
    s_a_mask    = s_a_valid ? a_q.mask    : '0;
  end

  logic resp;
  assign resp = (state_q == S_RESP);

  always_comb begin
    m_d_opcode = resp ? d_q.opcode : '0;
    m_d_size   = resp ? d_q.size   : '0;
    m_d_source = resp ? d_q.source : '0;
    m_d_data   = resp ? d_q.data   : '0;
    m_d_denied = resp ? d_q.denied : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      wdog_q  <= '0;
      a_q     <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_IDLE: begin
          if (found) begin
            own_q <= win;
            a_q   <= a_win;
          end
        end
        S_ISSUE: begin
          if (s_a_ready)
            wdog_q <= '0;
        end
        S_WAIT: begin
          wdog_q <= wdog_q + WD_W'(1);
          if (s_d_valid) begin
            d_q.opcode <= s_d_opcode;
            d_q.size   <= s_d_size;
            d_q.source <= s_d_source;
            d_q.data   <= s_d_data;
            d_q.denied <= s_d_denied;
          end else if (to_hit) begin
            // Hung slave: fabricate a denied ack shaped like the request.
            d_q.opcode <= (a_q.opcode == OP_GET) ? OP_ACK_D : OP_ACK;
            d_q.size   <= a_q.size;
            d_q.source <= a_q.source;
            d_q.data   <= '0;
            d_q.denied <= 1'b1;
          end
        end
        S_RESP: begin
          if (m_d_ready[own_q]) begin
            if (own_q == IDX_W'(N_REQ-1))
              ptr_q <= '0;
            else
              ptr_q <= own_q + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
